level_sequencer: RTL and testbench

Game-level controller for the cart game. It tracks the current level (0–7) and the player's remaining lives, and sequences the game through idle, play, pause-after-clear and pause-after-crash phases. Its `level` output feeds the HEX0 level display in place of the raw level switches. Its `blank` output lets the top level blank HEX0 so the digit blinks during pause phases.

---
 rtl/level_sequencer.sv | 139 +++++++++++++
 tb/tb_level_sequencer.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/level_sequencer.sv
// level_sequencer: game-level controller for the cart game.
// Tracks level (0-7) and lives, and sequences idle / play / pause-after-clear /
// pause-after-crash / over / won. Pause length and blink rate count `tick`.
// Optional feature macro: LEVEL_SELECT_EN adds the sel_level start-level port.
module level_sequencer #(
  parameter int unsigned START_LIVES = 3,
  parameter int unsigned PAUSE_TICKS = 8,
  parameter int unsigned BLINK_TICKS = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       start,
  input  logic       clear_pulse,
  input  logic       crash_pulse,
`ifdef LEVEL_SELECT_EN
  input  logic [2:0] sel_level,
`endif
  output logic [2:0] level,
  output logic [1:0] lives,
  output logic       blank,
  output logic       game_over,
  output logic       win
);

  localparam int unsigned PcntW   = $clog2(PAUSE_TICKS) + 1;
  localparam int unsigned BlinkSh = $clog2(BLINK_TICKS);
  localparam logic [PcntW-1:0] PcntLast  = PcntW'(PAUSE_TICKS - 1);
  localparam logic [PcntW-1:0] PcntOne   = PcntW'(1);
  localparam logic [1:0]       LivesInit = 2'(START_LIVES);

  typedef enum logic [2:0] {
    StIdle,
    StPlay,
    StCleared,
    StCrashed,
    StOver,
    StWon
  } state_e;

  state_e           state_q, state_d;
  logic [2:0]       level_q, level_d;
  logic [1:0]       lives_q, lives_d;
  logic [PcntW-1:0] pcnt_q, pcnt_d;
  logic [2:0]       start_level;

`ifdef LEVEL_SELECT_EN
  assign start_level = sel_level;
`else
  assign start_level = 3'd0;
`endif

  // State, level, lives and pause counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      level_q <= 3'd0;
      lives_q <= LivesInit;
      pcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      lives_q <= lives_d;
      pcnt_q  <= pcnt_d;
    end
  end

  // Next-state logic: game flow, level advance and life loss.
  always_comb begin
    state_d = state_q;
    level_d = level_q;
    lives_d = lives_q;
    pcnt_d  = pcnt_q;
    case (state_q)
      StIdle, StOver, StWon: begin
        if (start) begin
          state_d = StPlay;
          level_d = start_level;
          lives_d = LivesInit;
          pcnt_d  = '0;
        end
      end
      StPlay: begin
        // Crash wins over a simultaneous clear.
        if (crash_pulse) begin
          state_d = StCrashed;
          pcnt_d  = '0;
        end else if (clear_pulse) begin
          state_d = StCleared;
          pcnt_d  = '0;
        end
      end
      StCleared: begin
        if (tick) begin
          if (pcnt_q == PcntLast) begin
            pcnt_d = '0;
            if (level_q == 3'd7) begin
              state_d = StWon;
            end else begin
              level_d = level_q + 3'd1;
              state_d = StPlay;
            end
          end else begin
            pcnt_d = pcnt_q + PcntOne;
          end
        end
      end
      StCrashed: begin
        if (tick) begin
          if (pcnt_q == PcntLast) begin
            pcnt_d = '0;
            if (lives_q <= 2'd1) begin
              lives_d = 2'd0;
              state_d = StOver;
            end else begin
              lives_d = lives_q - 2'd1;
              state_d = StPlay;
            end
          end else begin
            pcnt_d = pcnt_q + PcntOne;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs decoded from registered state only.
  always_comb begin
    level     = level_q;
    lives     = lives_q;
    game_over = (state_q == StOver);
    win       = (state_q == StWon);
    // Blink: odd half-periods of the pause count blank the digit.
    blank     = ((state_q == StCleared) || (state_q == StCrashed)) &&
                (((pcnt_q >> BlinkSh) & PcntOne) != '0);
  end

endmodule

// File: tb/tb_level_sequencer.sv
// Scoreboard bench for level_sequencer: stimulus pushes expected outputs from a
// rule-level game model; a monitor pops and compares after every clock edge.
module tb_level_sequencer;

  localparam int unsigned StartLives = 3;
  localparam int unsigned PauseTicks = 8;
  localparam int unsigned BlinkTicks = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tick = 1'b0;
  logic       start = 1'b0;
  logic       clear_pulse = 1'b0;
  logic       crash_pulse = 1'b0;
`ifdef LEVEL_SELECT_EN
  logic [2:0] sel_level = 3'd0;
`endif
  logic [2:0] level;
  logic [1:0] lives;
  logic       blank;
  logic       game_over;
  logic       win;

  int checks = 0;
  int failures = 0;

  level_sequencer #(
    .START_LIVES(StartLives),
    .PAUSE_TICKS(PauseTicks),
    .BLINK_TICKS(BlinkTicks)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .tick       (tick),
    .start      (start),
    .clear_pulse(clear_pulse),
    .crash_pulse(crash_pulse),
`ifdef LEVEL_SELECT_EN
    .sel_level  (sel_level),
`endif
    .level      (level),
    .lives      (lives),
    .blank      (blank),
    .game_over  (game_over),
    .win        (win)
  );

  always #5 clk = ~clk;

  typedef struct {
    int lvl;
    int lif;
    int blk;
    int ovr;
    int wn;
  } exp_t;

  exp_t exp_q[$];

  // Game model: phase names are words, pause counts completed ticks.
  string m_phase = "idle";
  int    m_ticks = 0;
  int    m_level = 0;
  int    m_lives = StartLives;

  function automatic void m_reset();
    m_phase = "idle";
    m_ticks = 0;
    m_level = 0;
    m_lives = StartLives;
  endfunction

  function automatic void m_step(bit t, bit s, bit cl, bit cr, int sel);
    if (m_phase == "idle" || m_phase == "over" || m_phase == "won") begin
      if (s) begin
        m_phase = "play";
        m_level = sel;
        m_lives = StartLives;
      end
    end else if (m_phase == "play") begin
      if (cr) begin
        m_phase = "crashed";
        m_ticks = 0;
      end else if (cl) begin
        m_phase = "cleared";
        m_ticks = 0;
      end
    end else if (t) begin
      m_ticks++;
      if (m_ticks == PauseTicks) begin
        if (m_phase == "cleared") begin
          if (m_level == 7) m_phase = "won";
          else begin
            m_level++;
            m_phase = "play";
          end
        end else begin
          m_lives--;
          m_phase = (m_lives == 0) ? "over" : "play";
        end
      end
    end
  endfunction

  function automatic exp_t m_expect();
    exp_t e;
    bit paused;
    paused = (m_phase == "cleared") || (m_phase == "crashed");
    e.lvl = m_level;
    e.lif = m_lives;
    e.blk = (paused && ((m_ticks / BlinkTicks) % 2 == 1)) ? 1 : 0;
    e.ovr = (m_phase == "over") ? 1 : 0;
    e.wn  = (m_phase == "won") ? 1 : 0;
    return e;
  endfunction

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d time=%0t", name, act, req, $time);
    end
  endtask

  // One clock cycle of stimulus; expected post-edge outputs go to the scoreboard.
  task automatic cyc(input bit rst, input bit t, input bit s, input bit cl, input bit cr,
                     input int sel = 0);
    int sl;
    @(negedge clk);
    reset = rst;
    tick = t;
    start = s;
    clear_pulse = cl;
    crash_pulse = cr;
`ifdef LEVEL_SELECT_EN
    sel_level = 3'(sel);
    sl = sel;
`else
    sl = 0;
`endif
    if (rst) m_reset();
    else m_step(t, s, cl, cr, sl);
    exp_q.push_back(m_expect());
  endtask

  // Pause helper: n tick pulses with an idle cycle before each.
  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      cyc(0, 0, 0, 0, 0);
      cyc(0, 1, 0, 0, 0);
    end
  endtask

  // Monitor: compare DUT outputs against the scoreboard after each edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("level", int'(level), e.lvl);
        check("lives", int'(lives), e.lif);
        check("blank", int'(blank), e.blk);
        check("game_over", int'(game_over), e.ovr);
        check("win", int'(win), e.wn);
      end
    end
  end

  initial begin
    // Reset, then idle with clear/crash toggling (ignored outside play).
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) cyc(0, i % 2, 0, i % 2, (i + 1) % 2);

    // Clear and blink; the tick alongside clear must not count.
    cyc(0, 0, 1, 0, 0);
    cyc(0, 1, 0, 1, 0);
    ticks(8);
    cyc(0, 0, 0, 0, 0);

    // Three crash pauses to game over; start ignored mid-pause.
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 1, 0, 0);
    ticks(8);
    cyc(0, 0, 0, 0, 1);
    ticks(8);
    cyc(0, 0, 0, 0, 1);
    ticks(8);
    cyc(0, 0, 0, 1, 1);

    // Fresh game, reach level 2, then simultaneous clear and crash.
    cyc(0, 0, 1, 0, 0);
    for (int k = 0; k < 2; k++) begin
      cyc(0, 0, 0, 1, 0);
      ticks(8);
    end
    cyc(0, 0, 0, 1, 1);
    ticks(8);

    // Win by clearing through level 7, then restart.
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 1, 0, 0);
    for (int k = 0; k < 8; k++) begin
      cyc(0, 0, 0, 1, 0);
      ticks(8);
    end
    cyc(0, 1, 0, 1, 1);
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 0);

    // Start (selected level 5 if enabled), clear, reset mid-pause after 3 ticks.
    cyc(0, 0, 1, 0, 0, 5);
    cyc(0, 0, 0, 1, 0, 2);
    ticks(3);
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    m_reset();
    check("async_rst_level", int'(level), 0);
    check("async_rst_blank", int'(blank), 0);
    check("async_rst_lives", int'(lives), StartLives);
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);

    // Randomized play.
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 499) == 0), 1'($urandom_range(0, 1)),
          ($urandom_range(0, 19) == 0), ($urandom_range(0, 7) == 0),
          ($urandom_range(0, 11) == 0), int'($urandom_range(0, 7)));
    end

    repeat (3) @(posedge clk);
    #2;
    check("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
